pattern_serializer: RTL
=======================

Name: pattern_serializer

Overview:
- Upstream feeder for the pattern detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per cycle on a serial d_out/valid_o pair. That pair connects directly to the detector's d_in/valid_i inputs.
- Has a one-word holding register, so back-to-back words stream with no bubble between them.
- Provides a pause input, a busy flag and a sent-word counter for bench and system use.

Parameters:
- DATA_W, 8, width of each parallel input word. Legal values are 2 to 32.
- MSB_FIRST, 1. 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- CNT_W, 16, width of the sent-word counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- word_i  input  DATA_W  parallel word to serialize.
- word_valid_i  input  1  word_i is valid this cycle.
- word_ready_o  output  1  block can accept a word this cycle.
- en_i  input  1  serial-side enable. 0 pauses shifting.
- d_out  output  1  current serial bit; drives the detector's d_in.
- valid_o  output  1  d_out is valid; drives the detector's valid_i.
- busy_o  output  1  a word is in the shifter or in the holding register.
- word_cnt_o  output  CNT_W  count of words fully transmitted.

Behaviour:
- Reset (rst=0, asynchronous): shifter empty, hold empty, bit counter = 0, word_cnt_o = 0.
  - valid_o = 0, d_out = 0, busy_o = 0, word_ready_o = 1 (asserted once reset is released).
  - Reset during a word discards the partial word and any held word. valid_o drops immediately, without waiting for a clock edge.
- Storage: a shift register plus active flag (states IDLE/SHIFT), a bit counter of width clog2(DATA_W), and a holding register plus hold_full flag.
- Outputs:
  - word_ready_o = !hold_full, decoded from registers only.
  - d_out = the shifter's outgoing bit (MSB or LSB per MSB_FIRST); forced to 0 when IDLE.
  - valid_o = active && en_i.
  - busy_o = active || hold_full.
- Accept: a word is accepted at an edge where word_valid_i && word_ready_o.
  - If the shifter is IDLE, or is consuming its last bit at that same edge, and hold is empty, the word loads directly into the shifter.
  - Otherwise the word goes into the holding register.
  - Latency: a word accepted at edge N into an idle block gives valid_o=1 with its first bit in the cycle after edge N.
- Consume: a bit is consumed at every edge where valid_o=1. The shifter then advances one position and the bit counter increments.
- Last bit (bit counter = DATA_W-1, consumed):
  - word_cnt_o increments, wrapping modulo 2^CNT_W.
  - If hold is full, the held word loads into the shifter at the same edge, bit counter resets to 0 and hold_full clears. There is no idle cycle between words.
  - Else if a word is accepted at the same edge, it loads into the shifter.
  - Else the block goes to IDLE.
- en_i=0:
  - valid_o=0, shifter and bit counter frozen, d_out holds its value.
  - Accepts into hold/shifter still occur per the rules above. A direct load from IDLE is allowed while en_i=0.
- Throughput: continuous at DATA_W bits per DATA_W cycles while the upstream keeps word_valid_i high. word_ready_o is low only while hold is full.
- Input data: word_i is sampled only on accept edges. word_i changing while word_ready_o=0 has no effect.

Test Plan:
1. DATA_W=8, MSB_FIRST=1: reset, then send 0xB4 with en_i=1 → valid_o high 8 consecutive cycles starting the cycle after accept; d_out = 1,0,1,1,0,1,0,0; then valid_o=0, busy_o=0, word_cnt_o=1.
2. Back-to-back 0xA5 then 0x3C with word_valid_i held high → second word accepted into hold and word_ready_o=0 until the load; 16 consecutive valid cycles, bits 10100101 00111100; word_cnt_o=2.
3. Send 0xF0; drop en_i for 3 cycles after the 3rd bit → valid_o=0 for exactly those 3 cycles; full 11110000 sequence delivered in order; 8 total valid cycles; word_cnt_o=1.
4. MSB_FIRST=0, send 0x01 → d_out = 1 then seven 0s; word_cnt_o=1.
5. Send 0xFF; assert rst=0 asynchronously between edges after 4 bits → valid_o, busy_o and word_cnt_o go to 0 immediately. After release, send 0x81 → exactly bits 1,0,0,0,0,0,0,1 appear.
6. Chain into the pattern detector: 1000 random words → detector pattern-pulse count matches a software model run over the same 8000-bit stream; word_cnt_o=1000.

Source files
------------

// File: rtl/pattern_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out one bit
// per cycle on d_out/valid_o, with a one-word holding register for bubble-free streaming.
module pattern_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic              en_i,
    output logic              d_out,
    output logic              valid_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic [BW-1:0]      bit_cnt_q;
    logic [DATA_W-1:0]  hold_q;
    logic               hold_full_q;
    logic [CNT_W-1:0]   cnt_q;

    logic              active;
    logic              consume;
    logic              last_bit;
    logic              accept;
    logic              out_bit;
    logic [DATA_W-1:0] shifted;

    // Handshake: a word transfers at a rising edge where word_valid_i and word_ready_o are
    // both high; a serial bit transfers at every rising edge where valid_o is high.
    always_comb begin
        active   = (state_q == SHIFT);
        consume  = active && en_i;
        last_bit = consume && (bit_cnt_q == LAST_BIT);
        accept   = word_valid_i && !hold_full_q;
        out_bit  = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
        shifted  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (consume) begin
                if (last_bit) begin
                    cnt_q     <= cnt_q + 1'b1;
                    bit_cnt_q <= '0;
                    // Held word takes priority; a new word can only arrive when hold is empty.
                    if (hold_full_q) begin
                        shift_q     <= hold_q;
                        hold_full_q <= 1'b0;
                    end else if (accept) begin
                        shift_q <= word_i;
                    end else begin
                        state_q <= IDLE;
                    end
                end else begin
                    shift_q   <= shifted;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end

            if (accept && !active) begin
                state_q   <= SHIFT;
                shift_q   <= word_i;
                bit_cnt_q <= '0;
            end

            if (accept && active && !last_bit) begin
                hold_q      <= word_i;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign word_ready_o = !hold_full_q;
    assign d_out        = active ? out_bit : 1'b0;
    assign valid_o      = consume;
    assign busy_o       = active || hold_full_q;
    assign word_cnt_o   = cnt_q;

endmodule
